// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing: pixel counters, syncs, blank and line/frame strobes.
// Define VGA_PIX_DIV2_EN to run from a 2x clock with an internal pixel-enable toggle.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_end,
  output logic       frame_end,
  output logic       pix_en
);

  localparam int unsigned HTotal   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HsFirst  = H_VISIBLE + H_FRONT;
  localparam int unsigned HsLast   = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int unsigned VsFirst  = V_VISIBLE + V_FRONT;
  localparam int unsigned VsLast   = V_VISIBLE + V_FRONT + V_SYNC - 1;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       h_last;
  logic       v_last;

`ifdef VGA_PIX_DIV2_EN
  logic toggle_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= ~toggle_q;
    end
  end

  assign pix_en = toggle_q;
`else
  assign pix_en = 1'b1;
`endif

  assign h_last = (hc_q == 10'(HTotal - 1));
  assign v_last = (vc_q == 10'(VTotal - 1));

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Decode from next-state counts so the registered outputs line up with DrawX/DrawY.
  always_comb begin
    hs_d    = !((hc_d >= 10'(HsFirst)) && (hc_d <= 10'(HsLast)));
    vs_d    = !((vc_d >= 10'(VsFirst)) && (vc_d <= 10'(VsLast)));
    blank_d = (hc_d < 10'(H_VISIBLE)) && (vc_d < 10'(V_VISIBLE));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end

  assign DrawX     = hc_q;
  assign DrawY     = vc_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign blank     = blank_q;
  assign sync      = 1'b0;
  assign line_end  = pix_en && h_last;
  assign frame_end = line_end && v_last;

endmodule
